descrambler_16bit: RTL and testbench



---
 rtl/descrambler_16bit_pkg.sv | 24 ++
 rtl/descrambler_16bit_fifo2.sv | 53 +++++
 rtl/descrambler_16bit.sv | 69 ++++++
 tb/tb_descrambler_16bit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/descrambler_16bit_pkg.sv
// Shared constants and the 16-step Galois LFSR keystream function used by
// both the receive descrambler and the transmit scrambler.
package descrambler_16bit_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [WORD_W-1:0] DEFAULT_POLY = 16'hB400;

  // Returns {state after 16 steps, keystream}; keystream bit k is the bit
  // shifted out at step k.
  function automatic logic [2*WORD_W-1:0] lfsr_step16(input logic [WORD_W-1:0] state,
                                                      input logic [WORD_W-1:0] poly);
    logic [WORD_W-1:0] s;
    logic [WORD_W-1:0] k;
    s = state;
    k = '0;
    for (int i = 0; i < WORD_W; i++) begin
      k[i] = s[0];
      s = (s >> 1) ^ (s[0] ? poly : '0);
    end
    return {s, k};
  endfunction

endpackage

// File: rtl/descrambler_16bit_fifo2.sv
// Two-entry registered FIFO with valid/ready on both sides; in_ready depends
// only on the stored occupancy, never on out_ready.
module fifo2_16bit
  import descrambler_16bit_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign in_ready  = ~count[1];
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is left untouched when the last word leaves so out_data holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (push && pop) begin
      head <= in_data;
    end else if (push) begin
      if (count == 2'd0) begin
        head <= in_data;
      end else begin
        tail <= in_data;
      end
      count <= count + 2'd1;
    end else if (pop) begin
      if (count == 2'd2) begin
        head <= tail;
      end
      count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/descrambler_16bit.sv
// Receive-side word descrambler: XORs each accepted word with a 16-bit slice
// of a Galois LFSR keystream and buffers the result in a 2-entry FIFO.
module descrambler_16bit
  import descrambler_16bit_pkg::*;
#(
  parameter logic [WORD_W-1:0] SEED = DEFAULT_SEED,
  parameter logic [WORD_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              sync,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [WORD_W-1:0] word_cnt
);

  logic                accept;
  logic [WORD_W-1:0]   lfsr;
  logic [WORD_W-1:0]   start_state;
  logic [WORD_W-1:0]   next_state;
  logic [WORD_W-1:0]   keystream;
  logic [WORD_W-1:0]   word_out;
  logic [2*WORD_W-1:0] step;

  assign accept = in_valid & in_ready;

  // sync reseeds before this word's keystream is drawn.
  always_comb begin
    start_state = sync ? SEED : lfsr;
    step        = lfsr_step16(start_state, POLY);
    next_state  = step[2*WORD_W-1:WORD_W];
    keystream   = step[WORD_W-1:0];
    word_out    = bypass ? in_data : (in_data ^ keystream);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      word_cnt <= '0;
    end else if (accept) begin
      if (bypass) begin
        lfsr     <= start_state;
        word_cnt <= sync ? '0 : word_cnt;
      end else begin
        lfsr     <= next_state;
        word_cnt <= (sync ? '0 : word_cnt) + 16'd1;
      end
    end
  end

  fifo2_16bit #(
    .W(WORD_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (word_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_descrambler_16bit.sv
// Scoreboard bench for descrambler_16bit: the driver queues expected words,
// an independent monitor pops and compares on every output transfer.
module tb_descrambler_16bit;

  localparam logic [15:0] SEED_C  = 16'hACE1;
  // Keystream of the seed state, worked out by hand (16 Galois steps).
  localparam logic [15:0] K_SEED  = 16'hC4E1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sync;
  logic        bypass;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] word_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_lfsr;
  logic [15:0] model_cnt;

  always #5 clk = ~clk;

  descrambler_16bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sync     (sync),
    .bypass   (bypass),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .word_cnt (word_cnt)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model with the feedback taps (bits 15,13,12,10) written out.
  task automatic modelAccept(input logic [15:0] d, input logic s, input logic b,
                             output logic [15:0] e);
    logic [15:0] st;
    logic [15:0] k;
    logic        fb;
    st = s ? SEED_C : model_lfsr;
    k  = '0;
    if (b) begin
      e          = d;
      model_lfsr = st;
      model_cnt  = s ? 16'h0 : model_cnt;
    end else begin
      for (int i = 0; i < 16; i++) begin
        fb   = st[0];
        k[i] = fb;
        st   = {fb, st[15], st[14] ^ fb, st[13] ^ fb, st[12], st[11] ^ fb, st[10:1]};
      end
      e          = d ^ k;
      model_lfsr = st;
      model_cnt  = (s ? 16'h0 : model_cnt) + 16'h1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic s, input logic b,
                               input logic [15:0] e);
    bit got;
    got = 0;
    exp_q.push_back(e);
    in_data  = d;
    sync     = s;
    bypass   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    sync     = 1'b0;
    bypass   = 1'b0;
    in_data  = 16'h0;
    if (!got) begin
      void'(exp_q.pop_back());
      checkOutput("accept_timeout", 16'h0, 16'h1);
    end
  endtask

  task automatic sendModel(input logic [15:0] d, input logic s, input logic b);
    logic [15:0] e;
    modelAccept(d, s, b, e);
    applyStimulus(d, s, b, e);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput(name, 16'(exp_q.size()), 16'h0);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", out_data, 16'h0);
      end else begin
        checkOutput("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] plain;
    logic [15:0] scr;
    logic [15:0] e;
    logic [15:0] hold;
    logic [15:0] bp_words [4];
    int          acc;
    longint      t0;

    in_valid   = 1'b1;
    in_data    = 16'hFFFF;
    sync       = 1'b0;
    bypass     = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b1;
    model_lfsr = SEED_C;
    model_cnt  = 16'h0;

    // Asynchronous reset asserted mid-cycle while in_valid is high.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", {15'h0, out_valid}, 16'h0);
    checkOutput("reset_in_ready", {15'h0, in_ready}, 16'h1);
    checkOutput("reset_word_cnt", word_cnt, 16'h0);
    checkOutput("reset_out_data", out_data, 16'h0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    // First word after reset: zero in, bare keystream out.
    modelAccept(16'h0000, 1'b0, 1'b0, e);
    applyStimulus(16'h0000, 1'b0, 1'b0, K_SEED);
    waitDrain("drain_first");
    checkOutput("first_word_cnt", word_cnt, 16'h1);

    // Round trip of 64 words scrambled from the seed, back to back.
    applyStimulus(16'h0000, 1'b1, 1'b1, 16'h0000);
    modelAccept(16'h0000, 1'b1, 1'b1, e);
    t0 = $time;
    for (int i = 0; i < 64; i++) begin
      plain = 16'($urandom);
      modelAccept(plain, 1'b0, 1'b0, scr);
      applyStimulus(scr, 1'b0, 1'b0, plain);
    end
    checkOutput("throughput_cycles", 16'(($time - t0) / 10), 16'd64);
    waitDrain("drain_roundtrip");
    checkOutput("roundtrip_word_cnt", word_cnt, 16'd64);
    checkOutput("idle_out_valid", {15'h0, out_valid}, 16'h0);

    // Backpressure: downstream stalled for 5 cycles with input always offered.
    bp_words[0] = 16'h1111;
    bp_words[1] = 16'h2222;
    bp_words[2] = 16'h3333;
    bp_words[3] = 16'h4444;
    out_ready = 1'b0;
    acc  = 0;
    hold = 16'h0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = bp_words[acc];
      @(negedge clk);
      if (c == 2) hold = out_data;
      if (in_ready) begin
        modelAccept(bp_words[acc], 1'b0, 1'b0, e);
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepted", 16'(acc), 16'd2);
    checkOutput("bp_in_ready", {15'h0, in_ready}, 16'h0);
    checkOutput("bp_out_valid", {15'h0, out_valid}, 16'h1);
    checkOutput("bp_out_stable", out_data, hold);
    out_ready = 1'b1;
    waitDrain("drain_backpressure");
    sendModel(bp_words[2], 1'b0, 1'b0);
    sendModel(bp_words[3], 1'b0, 1'b0);
    waitDrain("drain_backpressure_tail");
    checkOutput("bp_word_cnt", word_cnt, model_cnt);

    // Sync after 10 words restarts the keystream from the seed.
    for (int i = 0; i < 10; i++) sendModel(16'(i * 16'h0101), 1'b0, 1'b0);
    modelAccept(16'h5A5A, 1'b1, 1'b0, e);
    applyStimulus(16'h5A5A, 1'b1, 1'b0, 16'h9EBB);
    waitDrain("drain_sync");
    checkOutput("sync_word_cnt", word_cnt, 16'h1);

    // Bypass passes data through and freezes both LFSR and counter.
    modelAccept(16'h0000, 1'b1, 1'b0, e);
    applyStimulus(16'h0000, 1'b1, 1'b0, K_SEED);
    applyStimulus(16'h1234, 1'b0, 1'b1, 16'h1234);
    modelAccept(16'h1234, 1'b0, 1'b1, e);
    waitDrain("drain_bypass");
    checkOutput("bypass_word_cnt", word_cnt, 16'h1);
    sendModel(16'h0000, 1'b0, 1'b0);
    waitDrain("drain_after_bypass");
    checkOutput("after_bypass_word_cnt", word_cnt, 16'h2);

    // Counter wrap: restart at 1, then 65534 more words reach 16'hFFFF.
    sendModel(16'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < 65534; i++) sendModel(16'(i), 1'b0, 1'b0);
    waitDrain("drain_preload");
    checkOutput("preload_word_cnt", word_cnt, 16'hFFFF);
    sendModel(16'hCAFE, 1'b0, 1'b0);
    waitDrain("drain_wrap");
    checkOutput("wrap_word_cnt", word_cnt, 16'h0000);
    modelAccept(16'hABCD, 1'b1, 1'b1, e);
    applyStimulus(16'hABCD, 1'b1, 1'b1, 16'hABCD);
    waitDrain("drain_sync_bypass");
    checkOutput("sync_bypass_word_cnt", word_cnt, 16'h0000);
    modelAccept(16'h0000, 1'b0, 1'b0, e);
    applyStimulus(16'h0000, 1'b0, 1'b0, K_SEED);
    waitDrain("drain_post_sync_bypass");
    checkOutput("post_sync_bypass_word_cnt", word_cnt, 16'h1);

    // Mid-stream reset discards buffered words and reseeds.
    out_ready = 1'b0;
    sendModel(16'h7777, 1'b0, 1'b0);
    sendModel(16'h8888, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {15'h0, out_valid}, 16'h0);
    checkOutput("midreset_in_ready", {15'h0, in_ready}, 16'h1);
    checkOutput("midreset_word_cnt", word_cnt, 16'h0);
    checkOutput("midreset_out_data", out_data, 16'h0);
    exp_q.delete();
    model_lfsr = SEED_C;
    model_cnt  = 16'h0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    modelAccept(16'h0000, 1'b0, 1'b0, e);
    applyStimulus(16'h0000, 1'b0, 1'b0, K_SEED);
    waitDrain("drain_final");
    checkOutput("final_word_cnt", word_cnt, 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
